// File: rtl/mat_mul_axis.sv
// mat_mul_axis: AXI-Stream square-matrix multiplier, R = A x B.
//   DIM = 2**DIM_LOG, SIZE = DIM*DIM, all matrices stored row-major.
//   Slave stream loads A (sel = 0) or B (sel = 1), with sel latched on the
//   first beat of each burst. A burst ends on tlast or on the SIZE-th beat.
//   A start request in IDLE runs a single-MAC sequencer. R then streams out
//   row-major on the master stream, and tlast is set on the final element.
// Ports:
//   s00_axi_aclk / s00_axi_aresetn : clock, synchronous active-low reset
//   s00_axis_*                     : element load stream (tready, tdata, tlast, tvalid)
//   m00_axis_*                     : result stream (tvalid, tdata, tstrb, tlast, tready)
//   sel, start                     : load target and compute request
//   busy, done                     : busy is high in COMPUTE/OUTPUT; done is a one-cycle end pulse
module mat_mul_axis #(
  parameter int  DIM_LOG    = 1,
  parameter int  DATA_WIDTH = 32,
  parameter int  SIGNED     = 0,
  parameter int  SATURATE   = 0,
  localparam int ACC_WIDTH  = 2 * DATA_WIDTH + DIM_LOG
) (
  input  logic                      s00_axi_aclk,
  input  logic                      s00_axi_aresetn,
  output logic                      s00_axis_tready,
  input  logic [DATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic                      s00_axis_tlast,
  input  logic                      s00_axis_tvalid,
  output logic                      m00_axis_tvalid,
  output logic [DATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [(DATA_WIDTH/8)-1:0] m00_axis_tstrb,
  output logic                      m00_axis_tlast,
  input  logic                      m00_axis_tready,
  input  logic                      sel,
  input  logic                      start,
  output logic                      busy,
  output logic                      done
);

  localparam int DIM  = 1 << DIM_LOG;
  localparam int SIZE = DIM * DIM;
  localparam int AW   = 2 * DIM_LOG;
  localparam int SW   = $clog2(DIM + 2);

  localparam logic [AW-1:0] ADDR_ZERO  = '0;
  localparam logic [AW-1:0] ADDR_LAST  = '1;
  localparam logic [AW:0]   OUT_END    = {1'b1, {AW{1'b0}}};
  localparam logic [SW-1:0] STEP_K_END = SW'(DIM);
  localparam logic [SW-1:0] STEP_LAST  = SW'(DIM + 1);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    OUTPUT
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] mat_a [SIZE];
  logic [DATA_WIDTH-1:0] mat_b [SIZE];
  logic [DATA_WIDTH-1:0] mat_r [SIZE];

  logic [AW-1:0]          load_addr;
  logic                   sel_q;
  logic                   eff_sel;
  logic                   beat_acc;

  logic [AW-1:0]          el_idx;
  logic [SW-1:0]          step;
  logic [DIM_LOG-1:0]     row_i, col_j, k_idx;
  logic [AW-1:0]          a_idx, b_idx;
  logic [DATA_WIDTH-1:0]  rd_a, rd_b;
  logic [2*DATA_WIDTH-1:0] a_ext, b_ext, prod;
  logic [ACC_WIDTH-1:0]   prod_ext;
  logic [ACC_WIDTH-1:0]   acc;
  logic [DATA_WIDTH-1:0]  r_fmt;
  logic                   el_done;
  logic                   last_mac_step;

  logic [AW:0]            out_addr;
  logic                   out_hs;
  logic                   out_load;

  assign m00_axis_tstrb = '1;

  // Load path: the target is taken live on the first beat, latched after.
  assign beat_acc = s00_axi_aresetn && s00_axis_tvalid && s00_axis_tready && (state == IDLE);
  assign eff_sel  = (load_addr == ADDR_ZERO) ? sel : sel_q;

  // Sequencer indices. Step 0..DIM-1 issue reads of k = step. Steps 1..DIM
  // accumulate the product read one cycle earlier. Step DIM+1 writes R.
  assign row_i   = el_idx[AW-1:DIM_LOG];
  assign col_j   = el_idx[DIM_LOG-1:0];
  assign k_idx   = step[DIM_LOG-1:0];
  assign a_idx   = {row_i, k_idx};
  assign b_idx   = {k_idx, col_j};
  assign el_done = (state == COMPUTE) && (step == STEP_LAST);
  assign last_mac_step = el_done && (el_idx == ADDR_LAST);

  assign out_hs   = m00_axis_tvalid && m00_axis_tready;
  assign out_load = (state == OUTPUT) && (!m00_axis_tvalid || m00_axis_tready) &&
                    (out_addr != OUT_END);

  always_comb begin
    a_ext = '0;
    b_ext = '0;
    if (SIGNED != 0) begin
      a_ext = {{DATA_WIDTH{rd_a[DATA_WIDTH-1]}}, rd_a};
      b_ext = {{DATA_WIDTH{rd_b[DATA_WIDTH-1]}}, rd_b};
    end else begin
      a_ext = {{DATA_WIDTH{1'b0}}, rd_a};
      b_ext = {{DATA_WIDTH{1'b0}}, rd_b};
    end
    prod = a_ext * b_ext;
    if (SIGNED != 0) prod_ext = {{DIM_LOG{prod[2*DATA_WIDTH-1]}}, prod};
    else             prod_ext = {{DIM_LOG{1'b0}}, prod};
  end

  // Result formatting. A signed value fits when every bit from the sign bit
  // of the result upward is a copy of the accumulator sign.
  always_comb begin
    r_fmt = acc[DATA_WIDTH-1:0];
    if (SATURATE != 0) begin
      if (SIGNED != 0) begin
        if (!(&acc[ACC_WIDTH-1:DATA_WIDTH-1]) && (|acc[ACC_WIDTH-1:DATA_WIDTH-1])) begin
          r_fmt = acc[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                   : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
      end else if (|acc[ACC_WIDTH-1:DATA_WIDTH]) begin
        r_fmt = '1;
      end
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) state <= IDLE;
    else                  state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (last_mac_step) state_next = OUTPUT;
      end
      OUTPUT: begin
        busy = 1'b1;
        if (out_hs && m00_axis_tlast) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Storage is intentionally not reset.
  always_ff @(posedge s00_axi_aclk) begin
    if (beat_acc) begin
      if (eff_sel) mat_b[load_addr] <= s00_axis_tdata;
      else         mat_a[load_addr] <= s00_axis_tdata;
    end
    if (s00_axi_aresetn && el_done) mat_r[el_idx] <= r_fmt;
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      load_addr       <= '0;
      sel_q           <= 1'b0;
      el_idx          <= '0;
      step            <= '0;
      rd_a            <= '0;
      rd_b            <= '0;
      acc             <= '0;
      out_addr        <= '0;
      s00_axis_tready <= 1'b0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
      m00_axis_tdata  <= '0;
      done            <= 1'b0;
    end else begin
      done            <= 1'b0;
      s00_axis_tready <= (state_next == IDLE);

      if (beat_acc) begin
        sel_q     <= eff_sel;
        load_addr <= (s00_axis_tlast || load_addr == ADDR_LAST) ? '0 : load_addr + 1'b1;
      end
      // The beat of this cycle (if any) is already written; drop the burst.
      if (state == IDLE && start) load_addr <= '0;

      if (state == COMPUTE) begin
        if (step < STEP_K_END) begin
          rd_a <= mat_a[a_idx];
          rd_b <= mat_b[b_idx];
        end
        if (step == '0)              acc <= '0;
        else if (step <= STEP_K_END) acc <= acc + prod_ext;
        if (el_done) begin
          step   <= '0;
          el_idx <= el_idx + 1'b1;
        end else begin
          step <= step + 1'b1;
        end
      end

      // The first result beat is loaded while the last element is being
      // written, because R[0] is already settled by then.
      if (last_mac_step) begin
        m00_axis_tvalid <= 1'b1;
        m00_axis_tdata  <= mat_r[ADDR_ZERO];
        m00_axis_tlast  <= 1'b0;
        out_addr        <= {{AW{1'b0}}, 1'b1};
      end else if (out_load) begin
        m00_axis_tvalid <= 1'b1;
        m00_axis_tdata  <= mat_r[out_addr[AW-1:0]];
        m00_axis_tlast  <= (out_addr[AW-1:0] == ADDR_LAST);
        out_addr        <= out_addr + 1'b1;
      end else if (out_hs) begin
        m00_axis_tvalid <= 1'b0;
        m00_axis_tlast  <= 1'b0;
      end

      if (state == OUTPUT && out_hs && m00_axis_tlast) begin
        done     <= 1'b1;
        out_addr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mat_mul_axis.sv
// tb_mat_mul_axis: four DUT variants (DIM_LOG = 1) share one input bus and
// run in lockstep:
//   inst0: 32-bit unsigned wrap
//   inst1: 32-bit signed saturate
//   inst2: 8-bit signed saturate
//   inst3: 8-bit signed wrap
// A behavioural model fills a scoreboard queue at each start, and every
// output handshake is compared against it.
module tb_mat_mul_axis;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tlast, sel, start, m_tready;
  logic [3:0]  s_tready, m_tvalid, m_tlast, busy, done;
  logic [31:0] d0, d1;
  logic [7:0]  d2, d3;
  logic [3:0]  strb0, strb1;
  logic        strb2, strb3;
  logic [31:0] md [4];

  typedef logic [3:0][31:0] exp_t;
  exp_t        exp_q [$];
  logic [31:0] ma [4];
  logic [31:0] mb [4];
  logic [31:0] ld [8];
  int          n_chk  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  always_comb begin
    md[0] = d0;
    md[1] = d1;
    md[2] = {24'd0, d2};
    md[3] = {24'd0, d3};
  end

  mat_mul_axis #(.DIM_LOG(1), .DATA_WIDTH(32), .SIGNED(0), .SATURATE(0)) u_uns (
    .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn), .s00_axis_tready(s_tready[0]),
    .s00_axis_tdata(s_tdata), .s00_axis_tlast(s_tlast), .s00_axis_tvalid(s_tvalid),
    .m00_axis_tvalid(m_tvalid[0]), .m00_axis_tdata(d0), .m00_axis_tstrb(strb0),
    .m00_axis_tlast(m_tlast[0]), .m00_axis_tready(m_tready), .sel(sel), .start(start),
    .busy(busy[0]), .done(done[0]));

  mat_mul_axis #(.DIM_LOG(1), .DATA_WIDTH(32), .SIGNED(1), .SATURATE(1)) u_ssat (
    .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn), .s00_axis_tready(s_tready[1]),
    .s00_axis_tdata(s_tdata), .s00_axis_tlast(s_tlast), .s00_axis_tvalid(s_tvalid),
    .m00_axis_tvalid(m_tvalid[1]), .m00_axis_tdata(d1), .m00_axis_tstrb(strb1),
    .m00_axis_tlast(m_tlast[1]), .m00_axis_tready(m_tready), .sel(sel), .start(start),
    .busy(busy[1]), .done(done[1]));

  mat_mul_axis #(.DIM_LOG(1), .DATA_WIDTH(8), .SIGNED(1), .SATURATE(1)) u_s8sat (
    .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn), .s00_axis_tready(s_tready[2]),
    .s00_axis_tdata(s_tdata[7:0]), .s00_axis_tlast(s_tlast), .s00_axis_tvalid(s_tvalid),
    .m00_axis_tvalid(m_tvalid[2]), .m00_axis_tdata(d2), .m00_axis_tstrb(strb2),
    .m00_axis_tlast(m_tlast[2]), .m00_axis_tready(m_tready), .sel(sel), .start(start),
    .busy(busy[2]), .done(done[2]));

  mat_mul_axis #(.DIM_LOG(1), .DATA_WIDTH(8), .SIGNED(1), .SATURATE(0)) u_s8wrap (
    .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn), .s00_axis_tready(s_tready[3]),
    .s00_axis_tdata(s_tdata[7:0]), .s00_axis_tlast(s_tlast), .s00_axis_tvalid(s_tvalid),
    .m00_axis_tvalid(m_tvalid[3]), .m00_axis_tdata(d3), .m00_axis_tstrb(strb3),
    .m00_axis_tlast(m_tlast[3]), .m00_axis_tready(m_tready), .sel(sel), .start(start),
    .busy(busy[3]), .done(done[3]));

  function automatic longint ext_el(logic [31:0] v, int inst);
    if (inst >= 2) return longint'($signed(v[7:0]));
    if (inst == 1) return longint'($signed(v));
    return longint'({32'd0, v});
  endfunction

  function automatic logic [31:0] model(int inst, int idx);
    longint acc;
    int i, j;
    acc = 0;
    i = idx / 2;
    j = idx % 2;
    for (int k = 0; k < 2; k++) acc += ext_el(ma[i*2+k], inst) * ext_el(mb[k*2+j], inst);
    case (inst)
      0: return acc[31:0];
      1: begin
        if (acc > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (acc < -64'sd2147483648) return 32'h8000_0000;
        return acc[31:0];
      end
      2: begin
        if (acc > 127)  return 32'h7F;
        if (acc < -128) return 32'h80;
        return {24'd0, acc[7:0]};
      end
      default: return {24'd0, acc[7:0]};
    endcase
  endfunction

  // Drives one burst from ld[]. The local model tracks the address and the
  // latched target exactly as the DUT should.
  task automatic load_burst(input bit tsel, input int n, input bit with_last, input bit flip_sel);
    int addr;
    bit lsel;
    addr = 0;
    lsel = tsel;
    for (int b = 0; b < n; b++) begin
      s_tvalid = 1'b1;
      s_tdata  = ld[b];
      s_tlast  = with_last && (b == n - 1);
      sel      = (flip_sel && b > 0) ? ~tsel : tsel;
      if (addr == 0) lsel = sel;
      if (lsel) mb[addr] = ld[b];
      else      ma[addr] = ld[b];
      addr = (s_tlast || addr == 3) ? 0 : addr + 1;
      n_chk++;
      if (s_tready !== 4'b1111) begin
        n_fail++;
        $display("FAIL load_tready: got %b want 1111", s_tready);
      end
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic start_run;
    exp_t e;
    for (int idx = 0; idx < 4; idx++) begin
      for (int k = 0; k < 4; k++) e[k] = model(k, idx);
      exp_q.push_back(e);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic collect(input int nbeats, input bit random_ready, input int stall_beat,
                         input bit check_lat);
    int beats, cyc, lat, stall_cnt;
    logic [31:0] hold_d;
    logic hold_l;
    bit rdy;
    exp_t e;
    beats = 0; cyc = 0; lat = 1; stall_cnt = 0;
    hold_d = '0; hold_l = 1'b0;
    if (check_lat) begin
      while (m_tvalid[0] !== 1'b1 && lat < 200) begin
        @(negedge clk);
        lat++;
      end
      n_chk++;
      if (m_tvalid[0] !== 1'b1 || lat > 18) begin
        n_fail++;
        $display("FAIL latency: got %0d cycles want <= 18", lat);
      end
    end
    while (beats < nbeats && cyc < 3000) begin
      rdy = random_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
      if (beats == stall_beat && stall_cnt < 20 && (stall_cnt > 0 || m_tvalid[0] === 1'b1)) begin
        rdy = 1'b0;
        if (stall_cnt == 0) begin
          hold_d = md[0];
          hold_l = m_tlast[0];
        end else begin
          n_chk++;
          if ({m_tvalid[0], m_tlast[0], md[0]} !== {1'b1, hold_l, hold_d}) begin
            n_fail++;
            $display("FAIL stall_stable: got v%b l%b %h want v1 l%b %h",
                     m_tvalid[0], m_tlast[0], md[0], hold_l, hold_d);
          end
        end
        stall_cnt++;
      end
      m_tready = rdy;
      n_chk++;
      if (done !== 4'b0000) begin
        n_fail++;
        $display("FAIL done_early: got %b want 0000", done);
      end
      if (m_tvalid[0] === 1'b1 && rdy) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_beat: got beat %0d want none", beats);
        end else begin
          e = exp_q.pop_front();
          for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (md[k] !== e[k]) begin
              n_fail++;
              $display("FAIL data_b%0d_i%0d: got %h want %h", beats, k, md[k], e[k]);
            end
          end
          n_chk++;
          if (m_tlast !== {4{beats == 3}}) begin
            n_fail++;
            $display("FAIL tlast_b%0d: got %b want %b", beats, m_tlast, {4{beats == 3}});
          end
          n_chk++;
          if (m_tvalid !== 4'b1111) begin
            n_fail++;
            $display("FAIL tvalid_all: got %b want 1111", m_tvalid);
          end
        end
        beats++;
      end
      @(negedge clk);
      cyc++;
    end
    m_tready = 1'b0;
    n_chk++;
    if (beats != nbeats) begin
      n_fail++;
      $display("FAIL beat_count: got %0d want %0d", beats, nbeats);
    end
    if (nbeats == 4) begin
      n_chk++;
      if ({done, busy, m_tvalid} !== {4'b1111, 4'b0000, 4'b0000}) begin
        n_fail++;
        $display("FAIL end_status: got done %b busy %b tvalid %b want 1111 0000 0000",
                 done, busy, m_tvalid);
      end
    end
  endtask

  task automatic check_done_low;
    @(negedge clk);
    n_chk++;
    if ({done, busy} !== 8'h00) begin
      n_fail++;
      $display("FAIL done_pulse: got done %b busy %b want 0000 0000", done, busy);
    end
  endtask

  task automatic test_reset;
    aresetn = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
    sel = 1'b0; start = 1'b0; m_tready = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({s_tready, m_tvalid, m_tlast, busy, done} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b %b %b %b %b want all 0", s_tready, m_tvalid, m_tlast, busy, done);
    end
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (md[k] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_tdata_i%0d: got %h want 0", k, md[k]);
      end
    end
    n_chk++;
    if ({strb0, strb1, strb2, strb3} !== 10'h3FF) begin
      n_fail++;
      $display("FAIL tstrb: got %b want all 1", {strb0, strb1, strb2, strb3});
    end
    aresetn = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({s_tready, busy} !== 8'hF0) begin
      n_fail++;
      $display("FAIL post_reset: got tready %b busy %b want 1111 0000", s_tready, busy);
    end
  endtask

  task automatic test_basic;
    ld = '{1, 2, 3, 4, 0, 0, 0, 0};
    load_burst(1'b0, 4, 1'b1, 1'b0);
    ld = '{5, 6, 7, 8, 0, 0, 0, 0};
    load_burst(1'b1, 4, 1'b1, 1'b0);
    start_run();
    collect(4, 1'b0, -1, 1'b1);
    check_done_low();
  endtask

  task automatic test_signed;
    ld = '{32'hFFFF_FFFF, 2, 3, 32'hFFFF_FFFC, 0, 0, 0, 0};
    load_burst(1'b0, 4, 1'b1, 1'b0);
    ld = '{1, 0, 0, 1, 0, 0, 0, 0};
    load_burst(1'b1, 4, 1'b1, 1'b0);
    start_run();
    collect(4, 1'b0, -1, 1'b0);
  endtask

  // Entered on the done cycle of the previous run.
  task automatic test_back_to_back;
    start_run();
    n_chk++;
    if ({busy, s_tready} !== 8'hF0) begin
      n_fail++;
      $display("FAIL b2b_accept: got busy %b tready %b want 1111 0000", busy, s_tready);
    end
    collect(4, 1'b0, -1, 1'b0);
    check_done_low();
  endtask

  task automatic test_saturate;
    ld = '{127, 127, 0, 0, 0, 0, 0, 0};
    load_burst(1'b0, 4, 1'b1, 1'b0);
    ld = '{127, 0, 127, 0, 0, 0, 0, 0};
    load_burst(1'b1, 4, 1'b1, 1'b0);
    start_run();
    collect(4, 1'b0, -1, 1'b0);
    check_done_low();
  endtask

  task automatic test_backpressure;
    ld = '{1, 2, 3, 4, 0, 0, 0, 0};
    load_burst(1'b0, 4, 1'b1, 1'b0);
    ld = '{5, 6, 7, 8, 0, 0, 0, 0};
    load_burst(1'b1, 4, 1'b1, 1'b0);
    start_run();
    collect(4, 1'b1, 2, 1'b0);
    check_done_low();
  endtask

  task automatic test_early_tlast;
    ld = '{9, 9, 9, 9, 0, 0, 0, 0};
    load_burst(1'b1, 4, 1'b1, 1'b0);
    ld = '{1, 2, 3, 4, 0, 0, 0, 0};
    load_burst(1'b0, 4, 1'b1, 1'b0);
    ld = '{1, 1, 0, 0, 0, 0, 0, 0};
    load_burst(1'b1, 2, 1'b1, 1'b1);
    start_run();
    collect(4, 1'b0, -1, 1'b0);
    check_done_low();
    ld = '{2, 3, 4, 5, 6, 0, 0, 0};
    load_burst(1'b1, 5, 1'b0, 1'b0);
    start_run();
    collect(4, 1'b0, -1, 1'b0);
    check_done_low();
  endtask

  task automatic test_reset_mid_output;
    start_run();
    collect(2, 1'b0, -1, 1'b0);
    aresetn  = 1'b0;
    m_tready = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({m_tvalid, busy, done, s_tready} !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_reset: got tvalid %b busy %b done %b tready %b want all 0",
               m_tvalid, busy, done, s_tready);
    end
    aresetn = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({s_tready, m_tvalid} !== 8'hF0) begin
      n_fail++;
      $display("FAIL mid_reset_release: got tready %b tvalid %b want 1111 0000", s_tready, m_tvalid);
    end
    exp_q.delete();
    start_run();
    collect(4, 1'b0, -1, 1'b0);
    check_done_low();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_back_to_back();
    test_saturate();
    test_backpressure();
    test_early_tlast();
    test_reset_mid_output();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
